// File: rtl/axis_router_pkg.sv
// Shared types and helpers for the AXI-Stream TID return router.
package axis_router_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int unsigned RR_MAX = 32;

  // First set bit of req strictly after 'last', wrapping modulo n; returns last if none set.
  function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] req,
                                          input int unsigned       last,
                                          input int unsigned       n);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= RR_MAX; i++) begin
      idx = (last + i) % n;
      if ((i <= n) && !found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_rr_dst_port.sv
// One destination of the return router: round-robin arbiter with packet lock
// and a single registered output stage.
module axis_rr_dst_port
  import axis_router_pkg::*;
#(
  parameter int unsigned NSRC       = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned HAS_LAST   = 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [NSRC-1:0]              i_req,
  input  logic [NSRC-1:0]              i_s_valid,
  input  logic [NSRC*DATA_WIDTH-1:0]   i_s_data,
  input  logic [NSRC*ID_WIDTH-1:0]     i_s_id,
  input  logic [NSRC-1:0]              i_s_last,
  output logic [NSRC-1:0]              o_lock_c,
  output logic [NSRC-1:0]              o_s_ready_c,
  output logic                         o_m_valid,
  input  logic                         i_m_ready,
  output logic [DATA_WIDTH-1:0]        o_m_data,
  output logic [ID_WIDTH-1:0]          o_m_id,
  output logic                         o_m_last
);

  localparam int unsigned GW = (NSRC > 1) ? $clog2(NSRC) : 1;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [GW-1:0]         r_grant;
  logic [GW-1:0]         w_grant_nxt;
  logic [GW-1:0]         r_last_grant;
  logic [GW-1:0]         w_last_grant_nxt;

  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [ID_WIDTH-1:0]   r_m_id;
  logic                  r_m_last;

  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [ID_WIDTH-1:0]   w_sel_id;
  logic                  w_out_free;
  logic                  w_accept;

  // Mux of the currently granted source
  always_comb begin
    w_sel_valid = i_s_valid[r_grant];
    w_sel_last  = i_s_last[r_grant];
    w_sel_data  = i_s_data[32'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
    w_sel_id    = i_s_id[32'(r_grant)*ID_WIDTH +: ID_WIDTH];
  end

  assign w_out_free = !r_m_valid || i_m_ready;
  assign w_accept   = (r_state == LOCKED) && w_sel_valid && w_out_free;

  always_comb begin
    o_lock_c    = '0;
    o_s_ready_c = '0;
    if (r_state == LOCKED) begin
      o_lock_c[r_grant]    = 1'b1;
      o_s_ready_c[r_grant] = w_out_free;
    end
  end

  // Arbitration / packet-lock next state
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      IDLE: begin
        if (|i_req) begin
          w_grant_nxt      = GW'(rr_pick(RR_MAX'(i_req), 32'(r_last_grant), NSRC));
          w_last_grant_nxt = w_grant_nxt;
          w_state_nxt      = LOCKED;
        end
      end
      LOCKED: begin
        if (w_accept && ((HAS_LAST == 0) || w_sel_last)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(NSRC - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Output stage: a load and a drain in the same cycle keep valid high
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_id    <= '0;
      r_m_last  <= 1'b0;
    end else if (w_accept) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_sel_data;
      r_m_id    <= w_sel_id;
      r_m_last  <= (HAS_LAST != 0) ? w_sel_last : 1'b1;
    end else if (i_m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign o_m_valid = r_m_valid;
  assign o_m_data  = r_m_data;
  assign o_m_id    = r_m_id;
  assign o_m_last  = r_m_last;

endmodule

// File: rtl/axis_id_return_router.sv
// TID-routed AXI-Stream return switch: NSRC response sources to NDST destinations.
// Define AXIS_ID_ROUTER_OOR_DROP_EN to discard out-of-range TID packets and flag drop_err.
module axis_id_return_router
  import axis_router_pkg::*;
#(
  parameter int unsigned NSRC       = 2,
  parameter int unsigned NDST       = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ID_BASE    = 0,
  parameter int unsigned HAS_LAST   = 1
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NSRC-1:0]            s_valid,
  output logic [NSRC-1:0]            s_ready,
  input  logic [NSRC*DATA_WIDTH-1:0] s_data,
  input  logic [NSRC*ID_WIDTH-1:0]   s_id,
  input  logic [NSRC-1:0]            s_last,
  output logic [NDST-1:0]            m_valid,
  input  logic [NDST-1:0]            m_ready,
  output logic [NDST*DATA_WIDTH-1:0] m_data,
  output logic [NDST*ID_WIDTH-1:0]   m_id,
  output logic [NDST-1:0]            m_last
`ifdef AXIS_ID_ROUTER_OOR_DROP_EN
  ,
  output logic                       drop_err
`endif
);

  logic [31:0]     w_tgt [NSRC];
  logic [NSRC-1:0] w_in_range;
  logic [NSRC-1:0] w_req   [NDST];
  logic [NSRC-1:0] w_lock  [NDST];
  logic [NSRC-1:0] w_ready [NDST];
  logic [NSRC-1:0] w_lock_any;
  logic [NSRC-1:0] w_ready_any;
  logic [NSRC-1:0] w_req_mask;

  // Unsigned wrap makes tid < ID_BASE land far above NDST, so one compare covers both bounds
  always_comb begin
    for (int unsigned k = 0; k < NSRC; k++) begin
      w_tgt[k]      = 32'(s_id[k*ID_WIDTH +: ID_WIDTH]) - ID_BASE;
      w_in_range[k] = (w_tgt[k] < NDST);
    end
  end

  always_comb begin
    w_lock_any  = '0;
    w_ready_any = '0;
    for (int unsigned d = 0; d < NDST; d++) begin
      w_lock_any  = w_lock_any | w_lock[d];
      w_ready_any = w_ready_any | w_ready[d];
    end
  end

`ifdef AXIS_ID_ROUTER_OOR_DROP_EN
  logic [NSRC-1:0] r_drop;
  logic [NSRC-1:0] w_drop_nxt;
  logic            r_drop_err;
  logic            w_drop_err_nxt;

  // A source enters DROP on an out-of-range head beat and leaves after the packet's last beat
  always_comb begin
    w_drop_nxt     = r_drop;
    w_drop_err_nxt = r_drop_err;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (r_drop[k]) begin
        if (s_valid[k] && ((HAS_LAST == 0) || s_last[k])) begin
          w_drop_nxt[k] = 1'b0;
        end
      end else if (s_valid[k] && !w_in_range[k] && !w_lock_any[k]) begin
        w_drop_nxt[k]  = 1'b1;
        w_drop_err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_drop     <= '0;
      r_drop_err <= 1'b0;
    end else begin
      r_drop     <= w_drop_nxt;
      r_drop_err <= w_drop_err_nxt;
    end
  end

  assign w_req_mask = w_lock_any | r_drop;
  assign s_ready    = w_ready_any | r_drop;
  assign drop_err   = r_drop_err;
`else
  assign w_req_mask = w_lock_any;
  assign s_ready    = w_ready_any;
`endif

  // Request matrix: a source locked anywhere requests nowhere else
  always_comb begin
    for (int unsigned d = 0; d < NDST; d++) begin
      for (int unsigned k = 0; k < NSRC; k++) begin
        w_req[d][k] = s_valid[k] && w_in_range[k] && (w_tgt[k] == d) && !w_req_mask[k];
      end
    end
  end

  for (genvar d = 0; d < NDST; d++) begin : g_dst
    axis_rr_dst_port #(
      .NSRC       (NSRC),
      .DATA_WIDTH (DATA_WIDTH),
      .ID_WIDTH   (ID_WIDTH),
      .HAS_LAST   (HAS_LAST)
    ) u_port (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .i_req       (w_req[d]),
      .i_s_valid   (s_valid),
      .i_s_data    (s_data),
      .i_s_id      (s_id),
      .i_s_last    (s_last),
      .o_lock_c    (w_lock[d]),
      .o_s_ready_c (w_ready[d]),
      .o_m_valid   (m_valid[d]),
      .i_m_ready   (m_ready[d]),
      .o_m_data    (m_data[d*DATA_WIDTH +: DATA_WIDTH]),
      .o_m_id      (m_id[d*ID_WIDTH +: ID_WIDTH]),
      .o_m_last    (m_last[d])
    );
  end

endmodule
